// File: rtl/wb_via_arbiter.sv
// wb_via_arbiter: round-robin arbiter sharing one registered-ack Wishbone VIA port, with a timeout watchdog
module wb_via_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic                              s_ack_i,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  output logic                              busy_o
);
  localparam int GW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                r_state, w_next;
  logic [GW-1:0]         r_grant, r_last, w_gnt, w_idx;
  logic                  w_any, w_timeout;
  logic [7:0]            r_cnt;
  logic                  r_err, r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_wdat, r_rdat;
  assign w_any     = |m_stb_i;
  assign w_timeout = r_cnt == 8'(TIMEOUT_CYCLES - 1);
  // round-robin pick: the lowest offset past last_grant wins, so scan offsets downward and let later hits override
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      w_idx = GW'((int'(r_last) + i) % NUM_MASTERS);
      if (m_stb_i[w_idx]) w_gnt = w_idx;
    end
  end
  // next state: one strobe, wait for ack or watchdog, one response cycle
  always_comb begin
    w_next = r_state == IDLE  ? (w_any ? ISSUE : IDLE) :
             r_state == ISSUE ? WAIT :
             r_state == WAIT  ? ((s_ack_i || w_timeout) ? RESP : WAIT) :
                                IDLE;
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end
  // capture the winning master's request; held until the next grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_grant <= '0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdat  <= '0;
    end else if (r_state == IDLE && w_any) begin
      r_grant <= w_gnt;
      r_we    <= m_we_i[w_gnt];
      r_adr   <= m_adr_i[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
      r_wdat  <= m_dat_i[w_gnt*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  // last_grant only moves once an access completes, so an aborted access leaves fairness untouched
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               r_last <= GW'(NUM_MASTERS - 1);
    else if (r_state == RESP)  r_last <= r_grant;
  end
  // watchdog counter and error flag; the ack check comes first so a tie is a normal completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == ISSUE) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == WAIT && !s_ack_i) begin
      if (w_timeout)             r_err <= 1'b1;
      else if (r_cnt != 8'hFF)   r_cnt <= r_cnt + 8'd1;
    end
  end
  // read data register: slave data on a read ack, zero on write ack or timeout, held otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 r_rdat <= '0;
    else if (r_state == WAIT && s_ack_i)         r_rdat <= r_we ? '0 : s_dat_i;
    else if (r_state == WAIT && w_timeout)       r_rdat <= '0;
  end
  assign s_stb_o = r_state == ISSUE;
  assign s_we_o  = r_we;
  assign s_adr_o = r_adr;
  assign s_dat_o = r_wdat;
  assign m_dat_o = r_rdat;
  assign busy_o  = r_state != IDLE;
  assign m_ack_o = r_state == RESP ? NUM_MASTERS'(1) << r_grant : '0;
  assign m_err_o = r_err ? m_ack_o : '0;
endmodule

// File: tb/tb_wb_via_arbiter.sv
// tb_wb_via_arbiter: directed checks of arbitration, timeout, reset and a VIA register model
module tb_wb_via_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  m_stb_i, m_we_i, m_ack_o, m_err_o;
  logic [7:0]  m_adr_i, m_dat_o, s_dat_o, s_dat_i;
  logic [15:0] m_dat_i;
  logic        s_stb_o, s_we_o, s_ack_i, busy_o;
  logic [3:0]  s_adr_o;
  logic [7:0]  regs [16];
  logic        auto_ack, slv_en, man_ack, prev_stb;
  logic [7:0]  auto_dat, man_dat;
  logic [1:0]  exp_g [4];
  int          wcount, tests, fails, n, cyc, k;

  wb_via_arbiter #(.NUM_MASTERS(2), .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // registered-ack VIA register file: ack and read data one cycle after the strobe
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'hA2 + 8'(i);
      auto_ack <= 1'b0;
      auto_dat <= 8'h00;
      wcount   <= 0;
    end else begin
      auto_ack <= s_stb_o && slv_en;
      auto_dat <= regs[s_adr_o];
      if (s_stb_o && s_we_o && slv_en) begin
        regs[s_adr_o] <= s_dat_o;
        wcount        <= wcount + 1;
      end
    end
  end
  assign s_ack_i = slv_en ? auto_ack : man_ack;
  assign s_dat_i = slv_en ? auto_dat : man_dat;

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    m_stb_i = 0; m_we_i = 0; m_adr_i = 0; m_dat_i = 0;
    slv_en = 1; man_ack = 0; man_dat = 0; rst_ni = 0;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    repeat (2) tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_adr", s_adr_o, 0);
    rst_ni = 1;
    tick();
    // single read of adr 3
    m_adr_i = 8'h03; m_we_i = 2'b00; m_stb_i = 2'b01;
    tick();
    chk("t1_stb", s_stb_o, 1);
    chk("t1_adr", s_adr_o, 4'h3);
    chk("t1_we", s_we_o, 0);
    chk("t1_busy", busy_o, 1);
    tick();
    chk("t1_stb_pulse", s_stb_o, 0);
    chk("t1_no_early_ack", m_ack_o, 0);
    tick();
    chk("t1_ack", m_ack_o, 2'b01);
    chk("t1_err", m_err_o, 2'b00);
    chk("t1_dat", m_dat_o, 8'hA5);
    m_stb_i = 2'b00;
    tick();
    chk("t1_ack_pulse", m_ack_o, 0);
    chk("t1_idle", busy_o, 0);
    chk("t1_dat_hold", m_dat_o, 8'hA5);
    // contention from reset
    rst_ni = 0;
    tick();
    rst_ni = 1;
    m_adr_i = 8'h21; m_stb_i = 2'b11;
    n = 0; cyc = 0; prev_stb = 0;
    while (n < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (s_stb_o) begin
        chk("t2_single_stb", prev_stb, 0);
        chk("t2_adr", s_adr_o, exp_g[n] == 2'b01 ? 4'h1 : 4'h2);
      end
      prev_stb = s_stb_o;
      if (m_ack_o != 0) begin
        chk("t2_grant", m_ack_o, exp_g[n]);
        n++;
      end
      m_stb_i = 2'b11 & ~m_ack_o;
    end
    chk("t2_count", n, 4);
    m_stb_i = 2'b00;
    tick();
    // timeout on a write from m1
    slv_en = 0;
    m_we_i = 2'b10; m_adr_i = 8'hB0; m_dat_i = 16'h4000; m_stb_i = 2'b10;
    tick();
    chk("t3_stb", s_stb_o, 1);
    chk("t3_adr", s_adr_o, 4'hB);
    chk("t3_we", s_we_o, 1);
    chk("t3_wdat", s_dat_o, 8'h40);
    k = 0;
    do begin
      tick();
      k++;
    end while (m_ack_o == 0 && k < 30);
    chk("t3_latency", k, 17);
    chk("t3_ack", m_ack_o, 2'b10);
    chk("t3_err", m_err_o, 2'b10);
    chk("t3_dat", m_dat_o, 0);
    m_stb_i = 2'b00; man_ack = 1; man_dat = 8'h77;
    tick();
    chk("t3_late_ack", m_ack_o, 0);
    chk("t3_late_err", m_err_o, 0);
    chk("t3_busy", busy_o, 0);
    chk("t3_dat_hold", m_dat_o, 0);
    man_ack = 0;
    tick();
    // ack in the same WAIT cycle as the timeout
    m_we_i = 2'b00; m_adr_i = 8'h05; m_stb_i = 2'b01;
    tick();
    chk("t4_issue", s_stb_o, 1);
    repeat (16) tick();
    chk("t4_no_early", m_ack_o, 0);
    man_ack = 1; man_dat = 8'h5C;
    tick();
    chk("t4_ack", m_ack_o, 2'b01);
    chk("t4_err", m_err_o, 2'b00);
    chk("t4_dat", m_dat_o, 8'h5C);
    man_ack = 0; m_stb_i = 2'b00;
    tick();
    // reset during WAIT of an m1 access
    m_adr_i = 8'h67; m_stb_i = 2'b10;
    tick();
    chk("t5_adr", s_adr_o, 4'h6);
    repeat (2) tick();
    #2 rst_ni = 0;
    #1;
    chk("t5_busy", busy_o, 0);
    chk("t5_stb", s_stb_o, 0);
    chk("t5_ack", m_ack_o, 0);
    chk("t5_dat", m_dat_o, 0);
    chk("t5_sadr", s_adr_o, 0);
    m_stb_i = 2'b11; slv_en = 1;
    tick();
    chk("t5_no_ack", m_ack_o, 0);
    rst_ni = 1;
    tick();
    chk("t5_regrant_stb", s_stb_o, 1);
    chk("t5_regrant_adr", s_adr_o, 4'h7);
    repeat (2) tick();
    chk("t5_ack_m0", m_ack_o, 2'b01);
    chk("t5_rdat", m_dat_o, 8'hA9);
    m_stb_i = 2'b00;
    tick();
    // write DDRA from m0, read it back from m1
    m_we_i = 2'b01; m_adr_i = 8'h33; m_dat_i = 16'h00FF; m_stb_i = 2'b01;
    repeat (3) tick();
    chk("t6_wack", m_ack_o, 2'b01);
    chk("t6_wdat", m_dat_o, 0);
    m_stb_i = 2'b00;
    tick();
    m_we_i = 2'b00; m_stb_i = 2'b10;
    repeat (3) tick();
    chk("t6_rack", m_ack_o, 2'b10);
    chk("t6_rdat", m_dat_o, 8'hFF);
    chk("t6_wcount", wcount, 1);
    m_stb_i = 2'b00;
    tick();
    chk("t6_idle", busy_o, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
